bomb_game_ctrl: RTL and testbench

- Game-level controller for one bomb round. Sits next to the countdown timer and closes the loop around it.
- Drives the timer's load interface (`sec`, `set`) and consumes its remaining-seconds output (`secLeft`).
- Aggregates module solved flags and strike pulses, applies strike time penalties, freezes the timer on defuse, and declares explosion.
- Also generates a per-second beep pulse for the buzzer.

---
 rtl/bomb_game_ctrl.sv | 151 +++++++++++++++
 tb/tb_bomb_game_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_game_ctrl.sv
// Round controller for one bomb: holds/loads the countdown timer, tracks strikes,
// applies time penalties, freezes on defuse, declares explosion and drives the beeper.
module bomb_game_ctrl #(
    parameter int clockSpeed  = 50000000,
    parameter int START_SEC   = 300,
    parameter int NUM_MODULES = 4,
    parameter int MAX_STRIKES = 3,
    parameter int PENALTY_SEC = 30,
    parameter int BEEP_CYCLES = 2500000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_MODULES-1:0] solved,
    input  logic                   strike,
    input  logic [16:0]            secLeft,
    output logic [16:0]            sec,
    output logic                   set,
    output logic                   armed,
    output logic                   exploded,
    output logic                   defused,
    output logic [1:0]             strikes,
    output logic                   beep,
    output logic [2:0]             o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_PENALTY,
        S_DEFUSED,
        S_EXPLODED
    } state_t;

    // Beep counter is sized from the clock rate since a beep never lasts a full second.
    localparam int             BW        = (clockSpeed > 1) ? $clog2(clockSpeed) : 1;
    localparam logic [BW-1:0]  BEEP_LOAD = BW'(BEEP_CYCLES - 1);
    localparam logic [16:0]    START_VAL = 17'(START_SEC);
    localparam logic [16:0]    PEN_SEC   = 17'(PENALTY_SEC);
    localparam logic [2:0]     MAX_S     = 3'(MAX_STRIKES);

    state_t          r_state;
    state_t          w_next_state;
    logic [1:0]      r_strikes;
    logic [16:0]     r_pen_val;
    logic [16:0]     r_frozen;
    logic [16:0]     r_prev_sec;
    logic [BW-1:0]   r_beep_cnt;
    logic            r_beep;

    logic            w_all_solved;
    logic            w_fatal;
    logic            w_strike_inc;
    logic            w_pen_load;
    logic            w_frozen_load;
    logic [16:0]     w_pen_next;

    assign w_all_solved = &solved;
    assign w_fatal      = strike && (({1'b0, r_strikes} + 3'd1) >= MAX_S);
    assign w_pen_next   = (secLeft > PEN_SEC) ? (secLeft - PEN_SEC) : 17'd0;

    always_comb begin
        w_next_state  = r_state;
        w_strike_inc  = 1'b0;
        w_pen_load    = 1'b0;
        w_frozen_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_ARMED;
            end
            S_ARMED: begin
                if (secLeft == 17'd0) begin
                    w_next_state = S_EXPLODED;
                end else if (w_fatal) begin
                    w_next_state = S_EXPLODED;
                    w_strike_inc = 1'b1;
                end else if (w_all_solved) begin
                    // A simultaneous non-fatal strike still counts but costs no time.
                    w_next_state  = S_DEFUSED;
                    w_frozen_load = 1'b1;
                    w_strike_inc  = strike;
                end else if (strike) begin
                    w_next_state = S_PENALTY;
                    w_strike_inc = 1'b1;
                    w_pen_load   = 1'b1;
                end
            end
            S_PENALTY: w_next_state = S_ARMED;
            default:   w_next_state = r_state;
        endcase
    end

    always_comb begin
        set      = 1'b1;
        sec      = 17'd0;
        armed    = 1'b0;
        exploded = 1'b0;
        defused  = 1'b0;
        case (r_state)
            S_IDLE:     sec = START_VAL;
            S_ARMED: begin
                set   = 1'b0;
                armed = 1'b1;
            end
            S_PENALTY: begin
                sec   = r_pen_val;
                armed = 1'b1;
            end
            S_DEFUSED: begin
                sec     = r_frozen;
                defused = 1'b1;
            end
            S_EXPLODED: exploded = 1'b1;
            default:    sec = 17'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_strikes  <= 2'd0;
            r_pen_val  <= 17'd0;
            r_frozen   <= 17'd0;
            r_prev_sec <= START_VAL;
            r_beep_cnt <= '0;
            r_beep     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_prev_sec <= secLeft;
            if (w_strike_inc && ({1'b0, r_strikes} < MAX_S)) r_strikes <= r_strikes + 2'd1;
            if (w_pen_load)    r_pen_val <= w_pen_next;
            if (w_frozen_load) r_frozen  <= secLeft;
            // Any change of the displayed seconds while live restarts the beep.
            if (r_state == S_ARMED && secLeft != r_prev_sec) begin
                r_beep_cnt <= BEEP_LOAD;
                r_beep     <= 1'b1;
            end else if (r_state == S_ARMED || r_state == S_PENALTY) begin
                if (r_beep_cnt != '0) r_beep_cnt <= r_beep_cnt - 1'b1;
                else                  r_beep     <= 1'b0;
            end else begin
                r_beep_cnt <= '0;
                r_beep     <= 1'b0;
            end
        end
    end

    assign strikes     = r_strikes;
    assign beep        = r_beep;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Bench for bomb_game_ctrl: a countdown-timer model closes the loop, and a round-level
// reference model predicts every output after every clock edge.
module tb_bomb_game_ctrl;

    localparam int CLK_HZ = 6;
    localparam int START  = 300;
    localparam int NMOD   = 4;
    localparam int MAXS   = 3;
    localparam int PEN    = 30;
    localparam int BEEPC  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [NMOD-1:0] solved;
    logic            strike;
    logic [16:0]     secLeft;
    logic [16:0]     sec;
    logic            set;
    logic            armed;
    logic            exploded;
    logic            defused;
    logic [1:0]      strikes;
    logic            beep;
    logic [2:0]      o_dbg_state;

    bomb_game_ctrl #(
        .clockSpeed (CLK_HZ),
        .START_SEC  (START),
        .NUM_MODULES(NMOD),
        .MAX_STRIKES(MAXS),
        .PENALTY_SEC(PEN),
        .BEEP_CYCLES(BEEPC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .solved     (solved),
        .strike     (strike),
        .secLeft    (secLeft),
        .sec        (sec),
        .set        (set),
        .armed      (armed),
        .exploded   (exploded),
        .defused    (defused),
        .strikes    (strikes),
        .beep       (beep),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Countdown timer owned by the bench: loads on set, else one second per CLK_HZ cycles.
    int t_sec = START;
    int t_div = 0;

    // Round-level reference model.
    bit m_started, m_in_pen, m_won, m_lost;
    int m_strikes, m_pen, m_frozen, m_prev, m_beep_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit live, counting;
        int s;
        s        = int'(secLeft);
        live     = m_started && !m_won && !m_lost;
        counting = live && !m_in_pen;
        if (reset) begin
            m_started = 0; m_in_pen = 0; m_won = 0; m_lost = 0;
            m_strikes = 0; m_prev = START; m_beep_left = 0;
        end else begin
            if (counting && s != m_prev) m_beep_left = BEEPC;
            else if (live && m_beep_left > 0) m_beep_left--;
            else if (!live) m_beep_left = 0;
            m_prev = s;
            if (!m_started) begin
                if (start) m_started = 1;
            end else if (m_in_pen) begin
                m_in_pen = 0;
            end else if (counting) begin
                if (s == 0) m_lost = 1;
                else if (strike && m_strikes + 1 >= MAXS) begin
                    m_strikes++; m_lost = 1;
                end else if (solved == {NMOD{1'b1}}) begin
                    m_won = 1; m_frozen = s;
                    if (strike) m_strikes++;
                end else if (strike) begin
                    m_strikes++; m_in_pen = 1;
                    m_pen = (s > PEN) ? s - PEN : 0;
                end
            end
        end
    endtask

    task automatic check_all();
        bit live;
        int e_sec;
        live  = m_started && !m_won && !m_lost;
        e_sec = !m_started ? START : m_in_pen ? m_pen : m_won ? m_frozen : 0;
        chk("set",      32'(set),      32'(!(live && !m_in_pen)));
        chk("sec",      32'(sec),      32'(e_sec));
        chk("armed",    32'(armed),    32'(live));
        chk("exploded", 32'(exploded), 32'(m_lost));
        chk("defused",  32'(defused),  32'(m_won));
        chk("strikes",  32'(strikes),  32'(m_strikes));
        chk("beep",     32'(beep),     32'(m_beep_left > 0));
    endtask

    task automatic step();
        bit          t_set;
        logic [16:0] t_val;
        model_step();
        t_set = (set === 1'b1);
        t_val = sec;
        @(posedge clk);
        #1;
        check_all();
        if (t_set) begin
            t_sec = int'(t_val);
            t_div = 0;
        end else if (++t_div == CLK_HZ) begin
            t_div = 0;
            if (t_sec > 0) t_sec--;
        end
        secLeft = 17'(t_sec);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic force_time(input int v);
        t_sec   = v;
        t_div   = 0;
        secLeft = 17'(v);
    endtask

    task automatic new_round();
        reset = 1'b1; start = 1'b0; strike = 1'b0; solved = '0;
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic hit();
        strike = 1'b1;
        step();
        strike = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; strike = 1'b0; solved = '0;
        secLeft = 17'(START);
        run(2);
        reset = 1'b0;

        // Idle hold, then arm
        run(5);
        chk("idle_sec", 32'(sec), 32'd300);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("arm_set", 32'(set), 32'd0);
        chk("arm_armed", 32'(armed), 32'd1);

        // Short countdown to zero with beeps on each decrement
        run(3);
        force_time(3);
        run(30);
        chk("timeout_exploded", 32'(exploded), 32'd1);
        chk("timeout_sec", 32'(sec), 32'd0);

        // Penalty at 100 -> 70, then penalty to zero and explosion
        new_round();
        force_time(100);
        hit();
        chk("pen_sec", 32'(sec), 32'd70);
        run(10);
        force_time(20);
        hit();
        chk("pen_zero_sec", 32'(sec), 32'd0);
        run(5);
        chk("pen_zero_exploded", 32'(exploded), 32'd1);

        // Three strikes: two penalties then a direct explosion
        new_round();
        force_time(200);
        hit(); run(5);
        hit(); run(5);
        hit();
        chk("third_strike_exploded", 32'(exploded), 32'd1);
        chk("third_strike_count", 32'(strikes), 32'd3);
        run(5);

        // Defuse at 57 holds the value; later inputs ignored
        new_round();
        force_time(57);
        solved = '1;
        step();
        run(100);
        chk("defused_sec", 32'(sec), 32'd57);
        hit(); run(3);
        start = 1'b1; run(3); start = 1'b0;

        // Zero time beats a full solve in the same cycle
        new_round();
        force_time(0);
        solved = '1;
        step();
        chk("zero_and_solved", 32'(exploded), 32'd1);
        solved = '0;

        // Mid-round reset
        new_round();
        force_time(150);
        hit(); run(4);
        reset = 1'b1; step(); reset = 1'b0;
        chk("midreset_sec", 32'(sec), 32'd300);
        run(3);

        // Randomized rounds
        for (int r = 0; r < 25; r++) begin
            new_round();
            force_time($urandom_range(0, 400));
            for (int c = 0; c < 200; c++) begin
                strike = (!strike && $urandom_range(0, 15) == 0);
                if ($urandom_range(0, 40) == 0) solved[$urandom_range(0, NMOD - 1)] = 1'b1;
                if ($urandom_range(0, 60) == 0) force_time($urandom_range(0, 60));
                reset = ($urandom_range(0, 300) == 0);
                if (reset) solved = '0;
                start = ($urandom_range(0, 20) == 0);
                step();
            end
            reset = 1'b0; strike = 1'b0; start = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
